serial2word_fanout: RTL and testbench



---
 rtl/serial2word_fanout.sv | 125 ++++++++++++
 tb/tb_serial2word_fanout.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial2word_fanout.sv
// ============================================================================
//  Module   : serial2word_fanout
//  Purpose  : Collects a qualified serial stream LSB-first into 6-bit frames
//             and fans each frame out to six registered outputs with a
//             one-cycle word_valid pulse. Optional macro PARITY_CHECK_EN adds
//             an odd-parity bit per frame and a parity_err output pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial2word_fanout (
    input  logic clock0,
    input  logic reset,
    input  logic in1,
    input  logic in_valid,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic word_valid
`ifdef PARITY_CHECK_EN
   ,output logic parity_err
`endif
);

`ifdef PARITY_CHECK_EN
    localparam int N = 7;
`else
    localparam int N = 6;
`endif
    localparam logic [2:0] LAST_BIT = 3'(N - 1);

    logic         s1_bit_q, s1_vld_q;
    logic         s2_bit_q, s2_vld_q;
    logic [2:0]   cnt_q, cnt_d;
    logic [N-1:0] shreg_q, shreg_d;
    logic [N-1:0] hold_q, hold_d;
    logic         done_q, done_d;
    logic [5:0]   out_q, out_d;
    logic         wv_q;

    // The current bit is folded into shreg_d first so the hold register
    // captures the complete frame on the completing edge.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        if (s2_vld_q) begin
            shreg_d[cnt_q] = s2_bit_q;
            if (cnt_q == LAST_BIT) begin
                hold_d = shreg_d;
                done_d = 1'b1;
                cnt_d  = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        out_d = out_q;
        if (done_q) begin
            out_d = hold_q[5:0];
        end
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            s1_bit_q <= 1'b0;
            s1_vld_q <= 1'b0;
            s2_bit_q <= 1'b0;
            s2_vld_q <= 1'b0;
            cnt_q    <= 3'd0;
            shreg_q  <= '0;
            hold_q   <= '0;
            done_q   <= 1'b0;
            out_q    <= 6'd0;
            wv_q     <= 1'b0;
        end else begin
            s1_bit_q <= in1;
            s1_vld_q <= in_valid;
            s2_bit_q <= s1_bit_q;
            s2_vld_q <= s1_vld_q;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            out_q    <= out_d;
            wv_q     <= done_q;
        end
    end

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;

    // Odd parity: a good frame has an odd number of ones across all 7 bits.
    always_comb begin
        perr_d = done_q & ~(^hold_q);
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

    assign out1       = out_q[0];
    assign out2       = out_q[1];
    assign out3       = out_q[2];
    assign out4       = out_q[3];
    assign out5       = out_q[4];
    assign out6       = out_q[5];
    assign word_valid = wv_q;

endmodule

`default_nettype wire

// File: tb/tb_serial2word_fanout.sv
// ============================================================================
//  Module   : tb_serial2word_fanout
//  Purpose  : Self-checking bench for serial2word_fanout (honours
//             PARITY_CHECK_EN when defined).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial2word_fanout;

`ifdef PARITY_CHECK_EN
    localparam int N = 7;
`else
    localparam int N = 6;
`endif

    logic clock0 = 1'b0;
    logic reset = 1'b0;
    logic in1 = 1'b0;
    logic in_valid = 1'b0;
    logic out1, out2, out3, out4, out5, out6, word_valid;
    logic perr_obs;
    logic [5:0] outs;

    serial2word_fanout dut (
        .clock0     (clock0),
        .reset      (reset),
        .in1        (in1),
        .in_valid   (in_valid),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .out5       (out5),
        .out6       (out6),
        .word_valid (word_valid)
`ifdef PARITY_CHECK_EN
       ,.parity_err (perr_obs)
`endif
    );

`ifndef PARITY_CHECK_EN
    assign perr_obs = 1'b0;
`endif
    assign outs = {out6, out5, out4, out3, out2, out1};

    always #5 clock0 = ~clock0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wv_count = 0;
    int last_wv_cyc = 0;
    int first_wv_cyc = 0;
    logic [5:0] first_wv_out = 6'd0;
    int perr_count = 0;
    int perr_cyc = 0;

    // Reference model: a bit sampled at edge k is accepted at edge k+2 unless
    // reset is seen on any of edges k..k+2; a full frame shows on the outputs
    // one edge after acceptance of its last bit, unless reset is on that edge.
    logic [2:0] rh = 3'b111;
    logic [2:0] vh = 3'b000;
    logic [2:0] bh = 3'b000;
    int         q_bits[$];
    logic [5:0] m_out = 6'd0;
    logic       m_wv = 1'b0;
    logic       m_perr = 1'b0;
    logic       pend = 1'b0;
    logic [5:0] pend_w = 6'd0;
    logic       pend_p = 1'b0;

    always @(posedge clock0) begin
        int ones;
        rh = {rh[1:0], reset};
        vh = {vh[1:0], in_valid};
        bh = {bh[1:0], in1};
        if (reset) begin
            q_bits.delete();
            m_out = 6'd0; m_wv = 1'b0; m_perr = 1'b0; pend = 1'b0;
        end else begin
            m_wv = 1'b0; m_perr = 1'b0;
            if (pend) begin
                m_out = pend_w; m_wv = 1'b1; m_perr = pend_p; pend = 1'b0;
            end
            if (vh[2] && rh == 3'b000) begin
                q_bits.push_back(int'(bh[2]));
                if (q_bits.size() == N) begin
                    ones = 0;
                    for (int i = 0; i < N; i++) begin
                        ones += q_bits[i];
                        if (i < 6) pend_w[i] = (q_bits[i] != 0);
                    end
                    pend_p = (N == 7) ? ((ones % 2) == 0) : 1'b0;
                    pend = 1'b1;
                    q_bits.delete();
                end
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic b);
        @(negedge clock0);
        reset = r; in_valid = v; in1 = b;
        @(posedge clock0);
        #1;
        cyc++;
        if (word_valid === 1'b1) begin
            wv_count++;
            last_wv_cyc = cyc;
            if (wv_count == 1) begin
                first_wv_cyc = cyc;
                first_wv_out = outs;
            end
        end
        if (perr_obs === 1'b1) begin
            perr_count++;
            perr_cyc = cyc;
        end
    endtask

    task automatic send_frame(input logic [6:0] w);
        for (int i = 0; i < N; i++) drive(1'b0, 1'b1, w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        wv_count = 0; perr_count = 0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if ({outs, word_valid, perr_obs} !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got outs=%b wv=%b perr=%b, expected all 0", outs, word_valid, perr_obs);
        end
    endtask

    task automatic test_single_frame();
        int e;
        clear_counts();
        send_frame(7'b1_101101);
        e = cyc;
        idle(5);
        checks++;
        if (wv_count !== 1) begin
            errors++; $display("FAIL single_pulses: got %0d expected 1", wv_count);
        end
        checks++;
        if (last_wv_cyc !== e + 3) begin
            errors++; $display("FAIL single_latency: got %0d expected %0d", last_wv_cyc - e, 3);
        end
        checks++;
        if (outs !== 6'b101101) begin
            errors++; $display("FAIL single_outs: got %b expected 101101", outs);
        end
    endtask

    task automatic test_gapped_frame();
        int s;
        logic [6:0] w;
        w = 7'b1_101101;
        clear_counts();
        s = cyc;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, w[i]);
        idle(3);
        for (int i = 3; i < N; i++) drive(1'b0, 1'b1, w[i]);
        idle(5);
        checks++;
        if (wv_count !== 1 || last_wv_cyc !== s + N + 6) begin
            errors++;
            $display("FAIL gapped_timing: got %0d pulses at offset %0d, expected 1 at %0d", wv_count, last_wv_cyc - s, N + 6);
        end
        checks++;
        if (outs !== 6'b101101) begin
            errors++; $display("FAIL gapped_outs: got %b expected 101101", outs);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_frame(7'b1_111111);
        send_frame(7'b0_100000);
        idle(5);
        checks++;
        if (wv_count !== 2 || last_wv_cyc - first_wv_cyc !== N) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses spaced %0d, expected 2 spaced %0d", wv_count, last_wv_cyc - first_wv_cyc, N);
        end
        checks++;
        if (first_wv_out !== 6'b111111) begin
            errors++; $display("FAIL b2b_first_outs: got %b expected 111111", first_wv_out);
        end
        checks++;
        if (outs !== 6'b100000) begin
            errors++; $display("FAIL b2b_second_outs: got %b expected 100000", outs);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== 6'd0) begin
            errors++; $display("FAIL midreset_clear: got %b expected 000000", outs);
        end
        send_frame(7'b0_101010);
        idle(5);
        checks++;
        if (wv_count !== 1) begin
            errors++; $display("FAIL midreset_pulses: got %0d expected 1", wv_count);
        end
        checks++;
        if (outs !== 6'b101010) begin
            errors++; $display("FAIL midreset_outs: got %b expected 101010", outs);
        end
    endtask

    task automatic test_reset_precedence();
        clear_counts();
        send_frame(7'b0_111000);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(4);
        checks++;
        if (wv_count !== 0 || perr_count !== 0) begin
            errors++; $display("FAIL precedence_pulse: got %0d pulses expected 0", wv_count);
        end
        checks++;
        if (outs !== 6'd0) begin
            errors++; $display("FAIL precedence_outs: got %b expected 000000", outs);
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        clear_counts();
        send_frame(7'b1_101101);
        idle(5);
        checks++;
        if (perr_count !== 0 || wv_count !== 1) begin
            errors++; $display("FAIL parity_good: got perr=%0d wv=%0d expected 0 and 1", perr_count, wv_count);
        end
        clear_counts();
        send_frame(7'b0_101101);
        idle(5);
        checks++;
        if (perr_count !== 1 || wv_count !== 1 || perr_cyc !== last_wv_cyc) begin
            errors++;
            $display("FAIL parity_bad: got perr=%0d at %0d wv=%0d at %0d, expected one coincident pulse", perr_count, perr_cyc, wv_count, last_wv_cyc);
        end
        checks++;
        if (outs !== 6'b101101) begin
            errors++; $display("FAIL parity_outs: got %b expected 101101", outs);
        end
    endtask
`endif

    task automatic test_random();
        logic r, v, b;
        int bad;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 3) != 0);
            b = 1'($urandom);
            drive(r, v, b);
            checks++;
            if ({outs, word_valid, perr_obs} !== {m_out, m_wv, m_perr}) begin
                errors++;
                if (bad < 20)
                    $display("FAIL random_cycle%0d: got outs=%b wv=%b perr=%b expected outs=%b wv=%b perr=%b",
                             i, outs, word_valid, perr_obs, m_out, m_wv, m_perr);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gapped_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_precedence();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
